// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB init sequencer: FSM states,
// OV7670 register addresses, init-table markers and error codes.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST_WR,
    RST_WAIT,
    RD_PID,
    RD_VER,
    CHECK,
    FETCH,
    TBL_WR,
    GAP,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] REG_COM7 = 8'h12;
  localparam logic [7:0] REG_PID  = 8'h0A;
  localparam logic [7:0] REG_VER  = 8'h0B;

  localparam logic [15:0] END = 16'hFFFF;
  localparam logic [7:0]  DLY = 8'hFE;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_PID     = 2'b10;

endpackage

// File: rtl/sccb_init_sequencer_if.sv
// Command/response bundle between the init sequencer (master) and CoreSCCB (slave).
interface sccb_init_sequencer_if;

  logic       sccb_start;
  logic       sccb_rw;
  logic [7:0] sccb_id_addr;
  logic [7:0] sccb_sub_addr;
  logic [7:0] sccb_data_in;
  logic [7:0] sccb_data_out;
  logic       sccb_done;

  modport master (
    output sccb_start, sccb_rw, sccb_id_addr, sccb_sub_addr, sccb_data_in,
    input  sccb_data_out, sccb_done
  );

  modport slave (
    input  sccb_start, sccb_rw, sccb_id_addr, sccb_sub_addr, sccb_data_in,
    output sccb_data_out, sccb_done
  );

endinterface

// File: rtl/sccb_init_rom.sv
// Combinational sensor init table, one {sub, data} entry per index.
// Swap this file to target a different sensor.
module sccb_init_rom
  import sccb_pkg::*;
#(
  parameter int ROM_AW = 6
) (
  input  logic [ROM_AW-1:0] index,
  output logic [15:0]       entry
);

  always_comb begin
    entry = END;
    case (int'(index))
      0:       entry = 16'h3A04;
      1:       entry = 16'h40D0;
      2:       entry = {DLY, 8'h04};
      3:       entry = 16'h1101;
      4:       entry = 16'h3E00;
      5:       entry = 16'h8C00;
      default: entry = END;
    endcase
  end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Drives CoreSCCB through soft reset, settle delay, PID/VER check and the
// init table; every state update is paced by the SCCB-rate tick.
module sccb_init_sequencer
  import sccb_pkg::*;
#(
  parameter int         ROM_AW          = 6,
  parameter int         RST_DELAY_TICKS = 100,
  parameter int         TIMEOUT_TICKS   = 4095,
  parameter logic [7:0] EXP_PID         = 8'h76,
  parameter logic [7:0] CAM_WR_ID       = 8'h42
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        tick,
  input  logic                        go,
  sccb_init_sequencer_if.master       bus,
  output logic                        busy,
  output logic                        init_done,
  output logic                        err,
  output logic [1:0]                  err_code,
  output logic [7:0]                  pid,
  output logic [7:0]                  ver,
  output logic [7:0]                  wr_count
);

  localparam logic [15:0] RST_LAST     = 16'(RST_DELAY_TICKS - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]  CAM_RD_ID    = CAM_WR_ID | 8'h01;

  state_t            state, state_n, gap_next, gap_next_n;
  logic [15:0]       cnt, cnt_n;
  logic [ROM_AW-1:0] index, index_n;
  logic [7:0]        pid_n, ver_n, wr_count_n;
  logic              init_done_n, err_n;
  logic [1:0]        err_code_n;
  logic [15:0]       rom_entry;
  logic [15:0]       dly_ticks;
  logic              in_txn, rd;

  sccb_init_rom #(.ROM_AW(ROM_AW)) u_rom (
    .index (index),
    .entry (rom_entry)
  );

  assign dly_ticks = {5'd0, rom_entry[7:0], 3'd0};
  assign in_txn    = state inside {RST_WR, RD_PID, RD_VER, TBL_WR};
  assign rd        = (state == RD_PID) || (state == RD_VER);
  assign busy      = !(state inside {IDLE, DONE, ERROR});

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      gap_next  <= IDLE;
      cnt       <= '0;
      index     <= '0;
      pid       <= '0;
      ver       <= '0;
      wr_count  <= '0;
      init_done <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (tick) begin
      state     <= state_n;
      gap_next  <= gap_next_n;
      cnt       <= cnt_n;
      index     <= index_n;
      pid       <= pid_n;
      ver       <= ver_n;
      wr_count  <= wr_count_n;
      init_done <= init_done_n;
      err       <= err_n;
      err_code  <= err_code_n;
    end
  end

  // cnt is shared: transaction timeout, reset settle and table delays all
  // restart it from zero whenever they begin.
  always_comb begin
    state_n     = state;
    gap_next_n  = gap_next;
    cnt_n       = cnt;
    index_n     = index;
    pid_n       = pid;
    ver_n       = ver;
    wr_count_n  = wr_count;
    init_done_n = init_done;
    err_n       = err;
    err_code_n  = err_code;
    case (state)
      IDLE, DONE, ERROR: begin
        if (go) begin
          init_done_n = 1'b0;
          err_n       = 1'b0;
          err_code_n  = ERR_NONE;
          wr_count_n  = '0;
          index_n     = '0;
          cnt_n       = '0;
          state_n     = RST_WR;
        end
      end
      RST_WR, RD_PID, RD_VER, TBL_WR: begin
        if (bus.sccb_done) begin
          cnt_n   = '0;
          state_n = GAP;
          if (state == RST_WR) begin
            gap_next_n = RST_WAIT;
          end else if (state == RD_PID) begin
            pid_n      = bus.sccb_data_out;
            gap_next_n = RD_VER;
          end else if (state == RD_VER) begin
            ver_n      = bus.sccb_data_out;
            gap_next_n = CHECK;
          end else begin
            wr_count_n = (wr_count == 8'hFF) ? wr_count : wr_count + 8'd1;
            index_n    = index + 1'b1;
            gap_next_n = FETCH;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_n      = '0;
          err_n      = 1'b1;
          err_code_n = ERR_TIMEOUT;
          state_n    = ERROR;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      GAP: begin
        cnt_n   = '0;
        state_n = gap_next;
      end
      RST_WAIT: begin
        if (cnt == RST_LAST) begin
          cnt_n   = '0;
          state_n = RD_PID;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      CHECK: begin
        if (pid == EXP_PID) begin
          state_n = FETCH;
        end else begin
          err_n      = 1'b1;
          err_code_n = ERR_PID;
          state_n    = ERROR;
        end
      end
      FETCH: begin
        // The last addressable entry doubles as an end marker so a table
        // missing its terminator cannot wrap back to index 0.
        if (index == {ROM_AW{1'b1}} || rom_entry == END) begin
          init_done_n = 1'b1;
          state_n     = DONE;
        end else if (rom_entry[15:8] == DLY) begin
          if (cnt + 16'd1 >= dly_ticks) begin
            cnt_n   = '0;
            index_n = index + 1'b1;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end else begin
          cnt_n   = '0;
          state_n = TBL_WR;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.sccb_start    = in_txn;
    bus.sccb_rw       = rd;
    bus.sccb_id_addr  = rd ? CAM_RD_ID : CAM_WR_ID;
    bus.sccb_sub_addr = 8'h00;
    bus.sccb_data_in  = 8'h00;
    case (state)
      RST_WR: begin
        bus.sccb_sub_addr = REG_COM7;
        bus.sccb_data_in  = 8'h80;
      end
      RD_PID: bus.sccb_sub_addr = REG_PID;
      RD_VER: bus.sccb_sub_addr = REG_VER;
      TBL_WR: begin
        bus.sccb_sub_addr = rom_entry[15:8];
        bus.sccb_data_in  = rom_entry[7:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Randomized bench for sccb_init_sequencer: a CoreSCCB BFM with random tick
// pacing and latency, checked against a transaction-level model of the sequence.
module tb_sccb_init_sequencer;

  localparam int RST_DELAY = 100;
  localparam int TIMEOUT   = 4095;
  localparam logic [7:0] EXP_PID = 8'h76;
  localparam logic [15:0] TBL [0:6] = '{16'h3A04, 16'h40D0, 16'hFE04, 16'h1101,
                                        16'h3E00, 16'h8C00, 16'hFFFF};

  typedef struct {
    logic       rw;
    logic [7:0] id;
    logic [7:0] sub;
    logic [7:0] data;
    int         hi;
    int         gap;
  } txn_t;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b0;
  logic       tick = 1'b0;
  logic       go = 1'b0;
  logic       busy, init_done, err;
  logic [1:0] err_code;
  logic [7:0] pid, ver, wr_count;

  sccb_init_sequencer_if bus ();

  sccb_init_sequencer #(
    .ROM_AW          (6),
    .RST_DELAY_TICKS (RST_DELAY),
    .TIMEOUT_TICKS   (TIMEOUT),
    .EXP_PID         (EXP_PID),
    .CAM_WR_ID       (8'h42)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .tick      (tick),
    .go        (go),
    .bus       (bus),
    .busy      (busy),
    .init_done (init_done),
    .err       (err),
    .err_code  (err_code),
    .pid       (pid),
    .ver       (ver),
    .wr_count  (wr_count)
  );

  always #5 PCLK = ~PCLK;

  int   vectors = 0;
  int   miscompares = 0;
  int   tick_count = 0;
  txn_t obs_q[$];
  txn_t exp_q[$];
  int   lat_q[$];
  txn_t cur;
  logic prev_start = 1'b0;
  int   lo_run = 0, hi_run = 0;
  int   bfm_hi = 0, bfm_lat = 1, bfm_fixed_lat = 0;
  logic [7:0] bfm_pid = 8'h76, bfm_ver = 8'h73;
  bit   bfm_hang_ver = 1'b0;
  int   exp_wr;
  logic exp_done, exp_err;
  logic [1:0] exp_code;
  logic [7:0] exp_pid = 8'h00, exp_ver = 8'h00;

  // Tick generator, transaction monitor and CoreSCCB BFM, all away from posedge.
  always @(negedge PCLK) begin
    bit t;
    bit hang;
    t = bit'($urandom_range(0, 1));
    if (PRESET) begin
      prev_start        = 1'b0;
      lo_run            = 0;
      hi_run            = 0;
      bfm_hi            = 0;
      bus.sccb_done     = 1'b0;
      bus.sccb_data_out = 8'h00;
    end else if (t) begin
      tick_count++;
      if (bus.sccb_start) begin
        if (!prev_start) begin
          cur.rw   = bus.sccb_rw;
          cur.id   = bus.sccb_id_addr;
          cur.sub  = bus.sccb_sub_addr;
          cur.data = bus.sccb_data_in;
          cur.gap  = lo_run;
          hi_run   = 0;
        end
        hi_run++;
      end else begin
        if (prev_start) begin
          cur.hi = hi_run;
          obs_q.push_back(cur);
          lo_run = 0;
        end
        lo_run++;
      end
      prev_start = bus.sccb_start;
      if (bus.sccb_start) begin
        if (bfm_hi == 0) begin
          bfm_lat = (bfm_fixed_lat > 0) ? bfm_fixed_lat : int'($urandom_range(1, 40));
          lat_q.push_back(bfm_lat);
        end
        bfm_hi++;
        hang = bfm_hang_ver && bus.sccb_rw && (bus.sccb_sub_addr == 8'h0B);
        bus.sccb_done = !hang && (bfm_hi >= bfm_lat);
      end else begin
        bfm_hi        = 0;
        bus.sccb_done = ($urandom_range(0, 3) == 0);
      end
      if (bus.sccb_sub_addr == 8'h0A)      bus.sccb_data_out = bfm_pid;
      else if (bus.sccb_sub_addr == 8'h0B) bus.sccb_data_out = bfm_ver;
      else                                 bus.sccb_data_out = 8'($urandom);
    end
    tick = t;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int target;
    int guard;
    target = tick_count + n;
    guard  = 0;
    while (tick_count < target && guard < 100 * n + 100) begin
      @(negedge PCLK);
      guard++;
    end
  endtask

  // Expected command stream and final status, straight from the sequence rules.
  task automatic build_model(input logic [7:0] p, input bit hang);
    txn_t t;
    int   extra;
    logic [15:0] e;
    exp_q.delete();
    exp_wr   = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_code = 2'b00;
    t = '{rw: 1'b0, id: 8'h42, sub: 8'h12, data: 8'h80, hi: 0, gap: -1};
    exp_q.push_back(t);
    t = '{rw: 1'b1, id: 8'h43, sub: 8'h0A, data: 8'h00, hi: 0, gap: 1 + RST_DELAY};
    exp_q.push_back(t);
    t = '{rw: 1'b1, id: 8'h43, sub: 8'h0B, data: 8'h00, hi: 0, gap: 1};
    exp_q.push_back(t);
    if (hang) begin
      exp_err  = 1'b1;
      exp_code = 2'b01;
    end else if (p != EXP_PID) begin
      exp_err  = 1'b1;
      exp_code = 2'b10;
    end else begin
      extra = 1;
      for (int i = 0; i < 64; i++) begin
        e = (i < 7) ? TBL[i] : 16'hFFFF;
        if (i == 63 || e == 16'hFFFF) break;
        if (e[15:8] == 8'hFE) begin
          extra += 8 * int'(e[7:0]);
        end else begin
          t = '{rw: 1'b0, id: 8'h42, sub: e[15:8], data: e[7:0], hi: 0, gap: 2 + extra};
          exp_q.push_back(t);
          extra = 0;
          exp_wr++;
        end
      end
      exp_done = 1'b1;
    end
  endtask

  task automatic compare_run(input bit hang);
    int n;
    checkOutput("txn_count", obs_q.size(), exp_q.size());
    checkOutput("lat_count", lat_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("txn%0d_rw", k), obs_q[k].rw, exp_q[k].rw);
      checkOutput($sformatf("txn%0d_id", k), obs_q[k].id, exp_q[k].id);
      checkOutput($sformatf("txn%0d_sub", k), obs_q[k].sub, exp_q[k].sub);
      if (!exp_q[k].rw)
        checkOutput($sformatf("txn%0d_data", k), obs_q[k].data, exp_q[k].data);
      if (k < lat_q.size())
        checkOutput($sformatf("txn%0d_hold", k), obs_q[k].hi,
                    (hang && k == 2) ? TIMEOUT : lat_q[k]);
      if (k > 0)
        checkOutput($sformatf("txn%0d_gap", k), obs_q[k].gap, exp_q[k].gap);
    end
    checkOutput("busy_end", busy, 1'b0);
    checkOutput("init_done", init_done, exp_done);
    checkOutput("err", err, exp_err);
    checkOutput("err_code", err_code, exp_code);
    checkOutput("pid", pid, exp_pid);
    checkOutput("ver", ver, exp_ver);
    checkOutput("wr_count", wr_count, exp_wr);
  endtask

  task automatic start_sequence();
    int guard;
    obs_q.delete();
    lat_q.delete();
    @(negedge PCLK);
    go = 1'b1;
    guard = 0;
    while (!busy && guard < 200) begin
      @(negedge PCLK);
      guard++;
    end
    go = 1'b0;
    checkOutput("busy_rise", busy, 1'b1);
    checkOutput("restart_done_clr", init_done, 1'b0);
    checkOutput("restart_err_clr", err, 1'b0);
  endtask

  task automatic applyStimulus(input logic [7:0] p, input logic [7:0] v, input bit hang,
                               input int fixed_lat, input bit poke_go);
    int guard;
    bfm_pid       = p;
    bfm_ver       = v;
    bfm_hang_ver  = hang;
    bfm_fixed_lat = fixed_lat;
    start_sequence();
    if (poke_go) begin
      repeat ($urandom_range(2, 8)) @(negedge PCLK);
      go = 1'b1;
      repeat (10) @(negedge PCLK);
      go = 1'b0;
    end
    guard = 0;
    while (busy && guard < 30000) begin
      @(negedge PCLK);
      guard++;
    end
    checkOutput("sequence_ends", busy, 1'b0);
    wait_ticks(4);
    exp_pid = p;
    if (!hang) exp_ver = v;
    build_model(p, hang);
    compare_run(hang);
  endtask

  initial begin
    int guard;
    bit found;
    #1 PRESET = 1'b1;
    #20;
    checkOutput("rst_start", bus.sccb_start, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_id", bus.sccb_id_addr, 8'h42);
    checkOutput("rst_status", {init_done, err, err_code, pid, ver, wr_count}, 28'h0);
    @(negedge PCLK);
    PRESET = 1'b0;

    wait_ticks(20);
    checkOutput("idle_done_ignored", {busy, bus.sccb_start}, 2'b00);

    $display("[TB] nominal bring-up, fixed 30-tick latency, go poked while busy");
    applyStimulus(8'h76, 8'h73, 1'b0, 30, 1'b1);
    $display("[TB] restart after done with random latency");
    applyStimulus(8'h76, 8'($urandom), 1'b0, 0, 1'b0);
    $display("[TB] PID mismatch");
    applyStimulus(8'h77, 8'h73, 1'b0, 0, 1'b0);
    $display("[TB] no response on VER read");
    applyStimulus(8'h76, 8'h55, 1'b1, 0, 1'b0);

    $display("[TB] reset during table write");
    bfm_pid       = 8'h76;
    bfm_ver       = 8'h73;
    bfm_hang_ver  = 1'b0;
    bfm_fixed_lat = 0;
    start_sequence();
    found = 1'b0;
    guard = 0;
    while (!found && guard < 5000) begin
      @(negedge PCLK);
      found = bus.sccb_start && !bus.sccb_rw && (bus.sccb_sub_addr == 8'h40);
      guard++;
    end
    checkOutput("tbl_wr_reached", found, 1'b1);
    #2 PRESET = 1'b1;
    #1;
    checkOutput("async_start_drop", bus.sccb_start, 1'b0);
    checkOutput("async_busy_drop", busy, 1'b0);
    checkOutput("async_status", {init_done, err, err_code, pid, ver, wr_count}, 28'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    exp_pid = 8'h00;
    exp_ver = 8'h00;
    applyStimulus(8'h76, 8'h73, 1'b0, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
